// File: rtl/exec_sequencer_if.sv
// Instruction handshake, register-file and ALU bus of the execute sequencer.
// The master modport is the sequencer; the slave modport is the surrounding
// register file / ALU / instruction source.
interface exec_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned OP_W   = 4
);
  // Instruction handshake
  logic                       in_valid;
  logic                       in_ready;
  logic [OP_W+3*REG_AW-1:0]   in_instr;
  // Register file
  logic                       rf_rw;
  logic [REG_AW-1:0]          rf_rs;
  logic [REG_AW-1:0]          rf_rt;
  logic [REG_AW-1:0]          rf_rd;
  logic [DATA_W-1:0]          rf_wdata;
  logic [DATA_W-1:0]          rf_rs_data;
  logic [DATA_W-1:0]          rf_rt_data;
  // ALU
  logic [DATA_W-1:0]          alu_a;
  logic [DATA_W-1:0]          alu_b;
  logic [OP_W-1:0]            alu_op;
  logic [DATA_W-1:0]          alu_out;
  // Status
  logic                       done;
  logic                       err;
  logic                       busy;

  modport master (
    input  in_valid, in_instr, rf_rs_data, rf_rt_data, alu_out,
    output in_ready, rf_rw, rf_rs, rf_rt, rf_rd, rf_wdata,
           alu_a, alu_b, alu_op, done, err, busy
  );

  modport slave (
    output in_valid, in_instr, rf_rs_data, rf_rt_data, alu_out,
    input  in_ready, rf_rw, rf_rs, rf_rt, rf_rd, rf_wdata,
           alu_a, alu_b, alu_op, done, err, busy
  );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle execute sequencer: IDLE -> READ -> EXEC -> WRITE -> IDLE.
// Accepts one register-register instruction, reads rs/rt from the register
// file, feeds the ALU and writes the result back to rd.
// Optional build macro EXEC_SEQ_PERF_EN adds retire_cnt / ill_cnt counters.
module exec_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned OP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef EXEC_SEQ_PERF_EN
  output logic [15:0]      retire_cnt,
  output logic [7:0]       ill_cnt,
`endif
  exec_sequencer_if.master bus
);

  localparam int unsigned InstrW = OP_W + 3 * REG_AW;
  localparam logic [OP_W-1:0] NumLegalOps = OP_W'(5);

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_e;

  state_e              state_q, state_d;
  logic [InstrW-1:0]   instr_q;
  logic [DATA_W-1:0]   result_q;

  // Last driven values, presented outside each output's owning state
  logic [REG_AW-1:0]   rs_q, rt_q, rd_q;
  logic [DATA_W-1:0]   alu_a_q, alu_b_q, wdata_q;
  logic [OP_W-1:0]     alu_op_q;

  logic [OP_W-1:0]     op_f;
  logic [REG_AW-1:0]   rd_f, rs_f, rt_f;
  logic                op_legal;
  logic                accept;

  assign op_f     = instr_q[InstrW-1 -: OP_W];
  assign rd_f     = instr_q[3*REG_AW-1 -: REG_AW];
  assign rs_f     = instr_q[2*REG_AW-1 -: REG_AW];
  assign rt_f     = instr_q[REG_AW-1:0];
  assign op_legal = (op_f < NumLegalOps);
  assign accept   = bus.in_valid & bus.in_ready;

  // Next-state logic: fixed four-step sequence, only IDLE waits
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRead;
      StRead:  state_d = StExec;
      StExec:  state_d = StWrite;
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction latch, ALU result capture and held copies of the outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q  <= '0;
      result_q <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      wdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) instr_q <= bus.in_instr;
        end
        StRead: begin
          rs_q <= rs_f;
          rt_q <= rt_f;
        end
        StExec: begin
          result_q <= bus.alu_out;
          alu_a_q  <= bus.rf_rs_data;
          alu_b_q  <= bus.rf_rt_data;
          alu_op_q <= op_f;
        end
        StWrite: begin
          rd_q    <= rd_f;
          wdata_q <= result_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs: each bus field is live in its owning state and held elsewhere
  always_comb begin
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    bus.rf_rs    = rs_q;
    bus.rf_rt    = rt_q;
    bus.rf_rd    = rd_q;
    bus.rf_wdata = wdata_q;
    bus.alu_a    = alu_a_q;
    bus.alu_b    = alu_b_q;
    bus.alu_op   = alu_op_q;
    bus.rf_rw    = 1'b0;
    bus.done     = 1'b0;
    bus.err      = 1'b0;

    bus.busy     = (state_q != StIdle);
    // Gated by rst so nothing is accepted while reset is held
    bus.in_ready = (state_q == StIdle) && !rst;

    unique case (state_q)
      StRead: begin
        bus.rf_rs = rs_f;
        bus.rf_rt = rt_f;
      end
      StExec: begin
        bus.alu_a  = bus.rf_rs_data;
        bus.alu_b  = bus.rf_rt_data;
        bus.alu_op = op_f;
      end
      StWrite: begin
        bus.rf_rd    = rd_f;
        bus.rf_wdata = result_q;
        bus.rf_rw    = op_legal && (rd_f != '0);
        bus.done     = 1'b1;
        bus.err      = !op_legal;
      end
      default: ;
    endcase
  end

`ifdef EXEC_SEQ_PERF_EN
  // Retire counter wraps; illegal-op counter saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
      ill_cnt    <= '0;
    end else if (state_q == StWrite) begin
      if (op_legal) begin
        retire_cnt <= retire_cnt + 16'd1;
      end else if (ill_cnt != 8'hFF) begin
        ill_cnt <= ill_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed plan cases plus a random
// instruction stream checked against an arithmetic register-file model.
module tb_exec_sequencer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OP_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_sequencer_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .OP_W(OP_W)) bus ();

`ifdef EXEC_SEQ_PERF_EN
  logic [15:0] retire_cnt;
  logic [7:0]  ill_cnt;
`endif

  exec_sequencer #(.DATA_W(DATA_W), .REG_AW(REG_AW), .OP_W(OP_W)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef EXEC_SEQ_PERF_EN
    .retire_cnt (retire_cnt),
    .ill_cnt    (ill_cnt),
`endif
    .bus        (bus)
  );

  // Environment: synchronous-read register file with a bench preload port
  logic [7:0] rf_mem [32];
  logic       pre_we   = 1'b0;
  logic [4:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) rf_mem[pre_addr] <= pre_data;
    else if (bus.rf_rw) rf_mem[bus.rf_rd] <= bus.rf_wdata;
    bus.rf_rs_data <= rf_mem[bus.rf_rs];
    bus.rf_rt_data <= rf_mem[bus.rf_rt];
  end

  // Environment: combinational ALU
  always_comb begin
    bus.alu_out = 8'hA5;
    case (bus.alu_op)
      4'd0: bus.alu_out = bus.alu_a + bus.alu_b;
      4'd1: bus.alu_out = bus.alu_a - bus.alu_b;
      4'd2: bus.alu_out = bus.alu_a & bus.alu_b;
      4'd3: bus.alu_out = bus.alu_a | bus.alu_b;
      4'd4: bus.alu_out = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 8'd1 : 8'd0;
      default: ;
    endcase
  end

  // Reference model state
  int ref_regs [32];
  int exp_retire = 0;
  int exp_ill    = 0;
  int last_wdata = 0;
  int n_checks   = 0;
  int n_fail     = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_result(input int op, input int a, input int b);
    int sa, sb;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return (sa < sb) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic preload_reg(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    ref_regs[a] = int'(d);
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issues one instruction and checks every phase. hold keeps in_valid high
  // through the operation (next call must follow immediately); no_wait drives
  // in the current cycle instead of the next negedge.
  task automatic run_instr(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs,
                           input logic [4:0] rt, input bit hold, input bit no_wait);
    int wait_cyc;
    int res;
    bit legal;
    bit exp_we;
    wait_cyc = 0;
    if (!no_wait) @(negedge clk);
    check_eq("idle_done", bus.done, 0);
    check_eq("idle_rf_rw", bus.rf_rw, 0);
    if (last_wdata >= 0) check_eq("wdata_hold", bus.rf_wdata, last_wdata);
    bus.in_valid = 1'b1;
    bus.in_instr = {op, rd, rs, rt};
    #1;
    while (!bus.in_ready && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_eq("in_ready", bus.in_ready, 1);
    if (hold || no_wait) check_eq("accept_latency", wait_cyc, 0);
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      return;
    end
    // READ
    @(negedge clk);
    if (!hold) bus.in_valid = 1'($urandom_range(0, 1));
    bus.in_instr = 19'($urandom);
    check_eq("read_busy", bus.busy, 1);
    check_eq("read_in_ready", bus.in_ready, 0);
    check_eq("read_rf_rs", bus.rf_rs, int'(rs));
    check_eq("read_rf_rt", bus.rf_rt, int'(rt));
    check_eq("read_rf_rw", bus.rf_rw, 0);
    // EXEC
    @(negedge clk);
    bus.in_instr = 19'($urandom);
    check_eq("exec_alu_a", bus.alu_a, ref_regs[rs]);
    check_eq("exec_alu_b", bus.alu_b, ref_regs[rt]);
    check_eq("exec_alu_op", bus.alu_op, int'(op));
    check_eq("exec_done", bus.done, 0);
    // WRITE
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
    legal  = (op < 4'd5);
    exp_we = legal && (rd != 5'd0);
    res    = ref_result(int'(op), ref_regs[rs], ref_regs[rt]);
    check_eq("write_done", bus.done, 1);
    check_eq("write_err", bus.err, legal ? 0 : 1);
    check_eq("write_rf_rw", bus.rf_rw, exp_we ? 1 : 0);
    check_eq("write_rf_rd", bus.rf_rd, int'(rd));
    check_eq("write_in_ready", bus.in_ready, 0);
    if (legal) begin
      check_eq("write_wdata", bus.rf_wdata, res);
      last_wdata = res;
      exp_retire = (exp_retire + 1) % 65536;
    end else begin
      last_wdata = -1;
      if (exp_ill < 255) exp_ill++;
    end
    if (exp_we) ref_regs[rd] = res;
  endtask

  initial begin
    bit prev_hold;
    bit hold;
    logic [3:0] rop;

    bus.in_valid = 1'b0;
    bus.in_instr = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_rf_rw", bus.rf_rw, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_err", bus.err, 0);
    check_eq("rst_addr", {bus.rf_rs, bus.rf_rt, bus.rf_rd}, 0);
    check_eq("rst_data", {bus.rf_wdata, bus.alu_a, bus.alu_b, bus.alu_op}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 32; i++) preload_reg(5'(i), 8'($urandom));

    // add r3 = r1 + r2
    preload_reg(5'd1, 8'd100);
    preload_reg(5'd2, 8'd27);
    run_instr(4'd0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("r3_readback", rf_mem[3], 127);

    // sub wraps: 5 - 10 = 251
    preload_reg(5'd2, 8'd5);
    preload_reg(5'd1, 8'd10);
    run_instr(4'd1, 5'd4, 5'd2, 5'd1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("r4_wrap", rf_mem[4], 251);

    // slt 3 < 9
    preload_reg(5'd1, 8'd3);
    preload_reg(5'd2, 8'd9);
    run_instr(4'd4, 5'd9, 5'd1, 5'd2, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("r9_slt", rf_mem[9], 1);

    // Dependent back-to-back with in_valid held
    run_instr(4'd3, 5'd5, 5'd1, 5'd2, 1'b1, 1'b0);
    run_instr(4'd2, 5'd10, 5'd5, 5'd6, 1'b0, 1'b0);

    // Illegal op: no write
    preload_reg(5'd6, 8'd77);
    run_instr(4'd9, 5'd6, 5'd1, 5'd2, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("r6_unchanged", rf_mem[6], 77);
`ifdef EXEC_SEQ_PERF_EN
    check_eq("ill_cnt_one", ill_cnt, 1);
`endif

    // rd = 0: done without write
    run_instr(4'd0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);

    // Reset during EXEC, then accept in the release cycle
    preload_reg(5'd7, 8'd55);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_instr = {4'd0, 5'd7, 5'd1, 5'd2};
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("exec_busy_pre_rst", bus.busy, 1);
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", bus.busy, 0);
    check_eq("midrst_rf_rw", bus.rf_rw, 0);
    check_eq("midrst_in_ready", bus.in_ready, 0);
    check_eq("midrst_done", bus.done, 0);
    exp_retire = 0;
    exp_ill    = 0;
    last_wdata = 0;
    @(negedge clk);
    check_eq("midrst_done2", bus.done, 0);
    check_eq("midrst_rf_rw2", bus.rf_rw, 0);
    rst = 1'b0;
    run_instr(4'd0, 5'd8, 5'd1, 5'd2, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("r7_unchanged", rf_mem[7], 55);

    // Random stream
    prev_hold = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!prev_hold && $urandom_range(0, 3) == 0) preload_reg(5'($urandom), 8'($urandom));
      rop  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      hold = (k < 39) && ($urandom_range(0, 1) == 1);
      run_instr(rop, 5'($urandom), 5'($urandom), 5'($urandom), hold, 1'b0);
      prev_hold = hold;
    end

    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 32; i++) check_eq($sformatf("reg%0d", i), rf_mem[i], ref_regs[i]);
`ifdef EXEC_SEQ_PERF_EN
    check_eq("retire_cnt", retire_cnt, exp_retire);
    check_eq("ill_cnt", ill_cnt, exp_ill);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
